// File: rtl/uart_pkg.sv
// UART shared definitions: line-state encoding and bit timing.
// Imported by the receiver and by a matching transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    // Clocks per bit; the +1 rounds slow so the sample point
    // never runs ahead of the line.
    function automatic int bit_period(input int clk_hz, input int baud);
        return (clk_hz / baud) + 1;
    endfunction

    // Clocks from the start edge to the middle of the start bit.
    function automatic int half_period(input int clk_hz, input int baud);
        return bit_period(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is chosen so the output matches the idle line level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Double-register the raw input to settle metastability.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling.
// Emits a one-cycle strobe per good frame or per framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_SPEED = 50_000000,
    parameter int BAUD      = 115200
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_stb,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int BIT_PERIOD  = bit_period(CLK_SPEED, BAUD);
    localparam int HALF_PERIOD = half_period(CLK_SPEED, BAUD);
    localparam int CW          = $clog2(BIT_PERIOD);

    localparam logic [CW-1:0] LAST_BIT  = CW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(HALF_PERIOD - 1);

    logic          w_rx;
    uart_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_stb;
    logic          r_ferr;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (w_rx)
    );

    // Frame FSM: counts sample intervals, assembles the byte, flags errors.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_stb   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_stb  <= 1'b0;
            r_ferr <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == LAST_HALF) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        // A high line at mid-start is a glitch.
                        r_state <= w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == LAST_BIT) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx;
                        if (r_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == LAST_BIT) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_stb   <= 1'b1;
                            r_data  <= r_shift;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line so it yields one error only.
                    r_cnt <= '0;
                    if (w_rx) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_data      = r_data;
    assign o_stb       = r_stb;
    assign o_frame_err = r_ferr;
    assign o_busy      = (r_state != ST_IDLE);

    a_cnt_range : assert property (
        @(posedge i_clk) disable iff (i_reset)
        int'(r_cnt) < BIT_PERIOD
    );

    a_state_legal : assert property (
        @(posedge i_clk) disable iff (i_reset)
        r_state inside {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK}
    );

    a_pulse_excl : assert property (
        @(posedge i_clk) disable iff (i_reset)
        !(r_stb && r_ferr)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1600 Hz / 100 baud.
// Received bytes are scored against a queue of sent bytes.
module tb_uart_rx;

    localparam int BP = 17;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       stb;
    logic       ferr;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stb   = 0;
    int n_ferr  = 0;

    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_SPEED (1600),
        .BAUD      (100)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_stb       (stb),
        .o_frame_err (ferr),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clk(BP);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop) exp_q.push_back(b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    // Output monitor: score every strobe and count error pulses.
    always @(negedge clk) begin
        if (stb || ferr) chk("excl", {31'd0, stb & ferr}, 32'd0);
        if (stb) begin
            n_stb++;
            if (exp_q.size() == 0) begin
                chk("stb_unexp", 32'd1, 32'd0);
            end else begin
                chk("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (ferr) n_ferr++;
    end

    initial begin
        int s0;
        int f0;
        logic seen;
        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_stb", {31'd0, stb}, 32'd0);
        chk("rst_ferr", {31'd0, ferr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        wait_clk(10);

        send_frame(8'hA5, 1'b1);
        wait_clk(20);
        chk("a5_stb", n_stb, 32'd1);
        chk("a5_ferr", n_ferr, 32'd0);
        chk("a5_hold", {24'd0, data}, 32'hA5);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        wait_clk(20);
        chk("b2b_stb", n_stb, 32'd4);
        chk("b2b_ferr", n_ferr, 32'd0);

        seen = 1'b0;
        rx = 1'b0;
        wait_clk(3);
        rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy) seen = 1'b1;
            wait_clk(1);
        end
        chk("gl_busy_seen", {31'd0, seen}, 32'd1);
        chk("gl_idle", {31'd0, busy}, 32'd0);
        chk("gl_stb", n_stb, 32'd4);
        chk("gl_ferr", n_ferr, 32'd0);

        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        wait_clk(100);
        chk("brk_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_clk(10);
        chk("fe_cnt", n_ferr, 32'd1);
        chk("fe_stb", n_stb, 32'd4);
        chk("fe_data", {24'd0, data}, 32'h3C);
        chk("fe_idle", {31'd0, busy}, 32'd0);
        wait_clk(20);

        s0 = n_stb;
        f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        rx = 1'b0;
        wait_clk(8);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        chk("rs_busy", {31'd0, busy}, 32'd0);
        wait_clk(40);
        chk("rs_stb", n_stb, s0);
        chk("rs_ferr", n_ferr, f0);
        chk("rs_data", {24'd0, data}, 32'h00);

        send_frame(8'h42, 1'b1);
        wait_clk(20);
        chk("42_stb", n_stb, s0 + 1);
        chk("42_data", {24'd0, data}, 32'h42);
        chk("q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
